// File: rtl/invader_pkg.sv
// invader_pkg: shared constants and types for the invader field renderer.
//   - Grid geometry, march limits and frame timing constants.
//   - March FSM state enum and row-class enum with class colours.
//   - 12x6 sprite bitmaps: 3 row classes x 2 animation frames.
//     Bit 11 of each row word is the leftmost sprite pixel (sx = 0).
package invader_pkg;

    localparam int unsigned ROWS            = 5;
    localparam int unsigned COLS            = 11;
    localparam int unsigned PITCH_X         = 64;
    localparam int unsigned PITCH_Y         = 32;
    localparam int unsigned INV_W           = 48;
    localparam int unsigned INV_H           = 24;
    localparam int unsigned X0              = 32;
    localparam int unsigned Y0              = 64;
    localparam int unsigned STEP_X          = 8;
    localparam int unsigned STEP_Y          = 16;
    localparam int unsigned X_MIN           = 32;
    localparam int unsigned X_MAX           = 992;
    localparam int unsigned BOTTOM_Y        = 640;
    localparam int unsigned VD              = 768;
    localparam int unsigned FRAMES_PER_STEP = 30;

    // Dead columns never shrink the field; the grid always marches as a full block.
    localparam int unsigned FIELD_W = (COLS - 1) * PITCH_X + INV_W;
    localparam int unsigned FIELD_H = (ROWS - 1) * PITCH_Y + INV_H;
    localparam int unsigned NUM_INV = ROWS * COLS;
    localparam int unsigned PX_SH   = $clog2(PITCH_X);
    localparam int unsigned PY_SH   = $clog2(PITCH_Y);

    typedef enum logic [1:0] {StMarchR, StMarchL, StDropToL, StDropToR} march_state_e;

    typedef enum logic [1:0] {ClassA, ClassB, ClassC} row_class_e;

    localparam logic [11:0] COLOR_A = 12'hF0F;
    localparam logic [11:0] COLOR_B = 12'h0FF;
    localparam logic [11:0] COLOR_C = 12'h0F0;

    // [class][anim][sy] -> 12-pixel row, bit 11 = leftmost pixel.
    localparam logic [11:0] SPRITE [3][2][6] = '{
        '{  // class A
            '{12'b100001100001, 12'b011111111110, 12'b110110011011,
              12'b111111111111, 12'b001001100100, 12'b010000000010},
            '{12'b100001100001, 12'b011111111110, 12'b110110011011,
              12'b111111111111, 12'b010010010010, 12'b100000000001}
        },
        '{  // class B
            '{12'b001000000100, 12'b000100001000, 12'b001111111100,
              12'b011011110110, 12'b111111111111, 12'b101000000101},
            '{12'b001000000100, 12'b100100001001, 12'b101111111101,
              12'b111011110111, 12'b011111111110, 12'b001000000100}
        },
        '{  // class C
            '{12'b000011110000, 12'b011111111110, 12'b111001100111,
              12'b111111111111, 12'b001100001100, 12'b011000000110},
            '{12'b000011110000, 12'b011111111110, 12'b111001100111,
              12'b111111111111, 12'b000110011000, 12'b110000000011}
        }
    };

    function automatic row_class_e row_class(input logic [5:0] row);
        if (row == 6'd0) begin
            return ClassA;
        end else if (row < 6'd3) begin
            return ClassB;
        end
        return ClassC;
    endfunction

    function automatic logic [11:0] class_color(input logic [1:0] cls);
        case (cls)
            2'(ClassA): return COLOR_A;
            2'(ClassB): return COLOR_B;
            default:    return COLOR_C;
        endcase
    endfunction

endpackage

// File: rtl/invader_rom.sv
// invader_rom: combinational sprite bitmap lookup.
// Ports:
//   i_class  row class (0=A, 1=B, 2=C)
//   i_anim   animation frame
//   i_sy     sprite row 0..5
//   i_sx     sprite column 0..11 (0 = leftmost)
//   o_bit    sprite pixel; 0 for out-of-range coordinates
module invader_rom
    import invader_pkg::*;
(
    input  logic [1:0] i_class,
    input  logic       i_anim,
    input  logic [2:0] i_sy,
    input  logic [3:0] i_sx,
    output logic       o_bit
);

    always_comb begin
        o_bit = 1'b0;
        if (i_class <= 2'd2 && i_sy <= 3'd5 && i_sx <= 4'd11) begin
            o_bit = SPRITE[i_class][i_anim][i_sy][4'd11 - i_sx];
        end
    end

endmodule

// File: rtl/invader_field.sv
// invader_field: renders the 5x11 marching invader grid and tracks hits.
// Sits right after the VGA sync generator and consumes its pixel coordinates.
// Ports:
//   i_clk, i_reset        clock; synchronous active-high reset
//   i_pixel_x, i_pixel_y  current pixel coordinate
//   i_video_on            visible-area flag
//   i_missile_on          player missile covers the current pixel
//   o_invader_on, o_rgb   registered invader pixel and colour (latency 1)
//   o_hit_pulse           one-cycle pulse on the first missile overlap of a frame
//   o_alive_count         invaders remaining; o_all_dead when zero
//   o_reached_bottom      sticky: grid bottom reached BOTTOM_Y
// Build option: define INVADER_SPEEDUP_EN to shorten the step period as invaders die.
module invader_field
    import invader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [10:0] i_pixel_x,
    input  logic [10:0] i_pixel_y,
    input  logic        i_video_on,
    input  logic        i_missile_on,
    output logic        o_invader_on,
    output logic [11:0] o_rgb,
    output logic        o_hit_pulse,
    output logic [5:0]  o_alive_count,
    output logic        o_all_dead,
    output logic        o_reached_bottom
);

    march_state_e         r_state, w_state_nxt;
    logic [10:0]          r_base_x, w_base_x_nxt;
    logic [10:0]          r_base_y, w_base_y_nxt;
    logic                 r_anim, w_anim_nxt;
    logic [4:0]           r_frame_cnt;
    logic                 r_vd_prev;
    logic [NUM_INV-1:0]   r_alive;
    logic [5:0]           r_alive_count;
    logic                 r_pending;
    logic [5:0]           r_pend_idx;
    logic                 r_hit_taken;
    logic                 r_reached_bottom;
    logic                 r_invader_on;
    logic [11:0]          r_rgb;
    logic                 r_hit_pulse;

    // Frame tick: pixel_y sits on VD for more than one clock, so detect the edge.
    logic w_at_vd, w_frame_tick, w_step, w_frozen, w_bottom;
    logic [4:0] w_period;

    assign w_at_vd      = (i_pixel_y == 11'(VD));
    assign w_frame_tick = w_at_vd & ~r_vd_prev;

`ifdef INVADER_SPEEDUP_EN
    logic [1:0] w_shift;
    logic [4:0] w_shifted;
    always_comb begin
        if (r_alive_count >= 6'd28) begin
            w_shift = 2'd0;
        end else if (r_alive_count >= 6'd14) begin
            w_shift = 2'd1;
        end else if (r_alive_count >= 6'd4) begin
            w_shift = 2'd2;
        end else begin
            w_shift = 2'd3;
        end
    end
    assign w_shifted = 5'(FRAMES_PER_STEP) >> w_shift;
    assign w_period  = (w_shifted == 5'd0) ? 5'd1 : w_shifted;
`else
    assign w_period = 5'(FRAMES_PER_STEP);
`endif

    // >= rather than == so a period that shrinks below the count still wraps.
    assign w_step   = w_frame_tick && (r_frame_cnt >= w_period - 5'd1);
    assign w_frozen = o_all_dead | r_reached_bottom;
    assign w_bottom = ({1'b0, r_base_y} + 12'(FIELD_H)) >= 12'(BOTTOM_Y);

    // Render path: 12-bit two's complement offsets, bit 11 set means left/above the grid.
    logic [11:0] w_rel_x, w_rel_y;
    logic [4:0]  w_col;
    logic [5:0]  w_row, w_idx;
    logic [5:0]  w_off_x;
    logic [4:0]  w_off_y;
    logic [1:0]  w_class;
    logic        w_valid, w_bit, w_hit_comb, w_hit_new;

    assign w_rel_x = {1'b0, i_pixel_x} - {1'b0, r_base_x};
    assign w_rel_y = {1'b0, i_pixel_y} - {1'b0, r_base_y};
    assign w_col   = 5'(w_rel_x[10:0] >> PX_SH);
    assign w_row   = 6'(w_rel_y[10:0] >> PY_SH);
    assign w_off_x = w_rel_x[PX_SH-1:0];
    assign w_off_y = w_rel_y[PY_SH-1:0];
    assign w_valid = !w_rel_x[11] && !w_rel_y[11] && (w_col < 5'(COLS)) && (w_row < 6'(ROWS))
                     && (w_off_x < 6'(INV_W)) && (w_off_y < 5'(INV_H));
    assign w_idx   = w_row * 6'(COLS) + 6'(w_col);
    assign w_class = row_class(w_row);

    invader_rom u_rom (
        .i_class (w_class),
        .i_anim  (r_anim),
        .i_sy    (w_off_y[4:2]),
        .i_sx    (w_off_x[5:2]),
        .o_bit   (w_bit)
    );

    assign w_hit_comb = i_video_on & w_valid & r_alive[w_idx] & w_bit;
    assign w_hit_new  = w_hit_comb & i_missile_on & ~r_hit_taken;

    // March FSM next state.
    always_comb begin
        w_state_nxt  = r_state;
        w_base_x_nxt = r_base_x;
        w_base_y_nxt = r_base_y;
        w_anim_nxt   = r_anim;
        if (w_step && !w_frozen) begin
            w_anim_nxt = ~r_anim;
            unique case (r_state)
                StMarchR: begin
                    if (({1'b0, r_base_x} + 12'(FIELD_W + STEP_X)) > 12'(X_MAX)) begin
                        w_state_nxt = StDropToL;
                    end else begin
                        w_base_x_nxt = r_base_x + 11'(STEP_X);
                    end
                end
                StMarchL: begin
                    if (r_base_x < 11'(X_MIN + STEP_X)) begin
                        w_state_nxt = StDropToR;
                    end else begin
                        w_base_x_nxt = r_base_x - 11'(STEP_X);
                    end
                end
                StDropToL: begin
                    w_base_y_nxt = r_base_y + 11'(STEP_Y);
                    w_state_nxt  = StMarchL;
                end
                StDropToR: begin
                    w_base_y_nxt = r_base_y + 11'(STEP_Y);
                    w_state_nxt  = StMarchR;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= StMarchR;
            r_base_x <= 11'(X0);
            r_base_y <= 11'(Y0);
            r_anim   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_base_x <= w_base_x_nxt;
            r_base_y <= w_base_y_nxt;
            r_anim   <= w_anim_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_frame_cnt      <= 5'd0;
            r_vd_prev        <= 1'b0;
            r_alive          <= '1;
            r_alive_count    <= 6'(NUM_INV);
            r_pending        <= 1'b0;
            r_pend_idx       <= 6'd0;
            r_hit_taken      <= 1'b0;
            r_reached_bottom <= 1'b0;
            r_invader_on     <= 1'b0;
            r_rgb            <= 12'h000;
            r_hit_pulse      <= 1'b0;
        end else begin
            r_vd_prev        <= w_at_vd;
            r_invader_on     <= w_hit_comb;
            r_rgb            <= w_hit_comb ? class_color(w_class) : 12'h000;
            r_hit_pulse      <= w_hit_new;
            r_reached_bottom <= r_reached_bottom | w_bottom;
            if (w_frame_tick) begin
                r_frame_cnt <= w_step ? 5'd0 : r_frame_cnt + 5'd1;
                r_hit_taken <= 1'b0;
                if (r_pending) begin
                    r_alive[r_pend_idx] <= 1'b0;
                    r_pending           <= 1'b0;
                    if (r_alive_count != 6'd0) begin
                        r_alive_count <= r_alive_count - 6'd1;
                    end
                end
            end
            // Only the first overlap of a frame is latched for the next kill.
            if (w_hit_new) begin
                r_hit_taken <= 1'b1;
                r_pending   <= 1'b1;
                r_pend_idx  <= w_idx;
            end
        end
    end

    assign o_invader_on     = r_invader_on;
    assign o_rgb            = r_rgb;
    assign o_hit_pulse      = r_hit_pulse;
    assign o_alive_count    = r_alive_count;
    assign o_all_dead       = (r_alive_count == 6'd0);
    assign o_reached_bottom = r_reached_bottom;

endmodule
